fifo: RTL and testbench
=======================

Name: fifo

Overview:
Synchronous single-clock first-in/first-out buffer with parameterised data width and depth (2**ADDR_WIDTH entries). Producers push words with wr_en; consumers pop with rd_en and see the word on a registered data_out one clock later. Status flags full/empty gate the handshake. Used as a generic rate/elasticity buffer between two blocks in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored word in bits
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH (default 16 entries)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset; asynchronous, active-low (asserted when 0)
wr_en  input  1  write request; sampled at rising clk
rd_en  input  1  read request; sampled at rising clk
data_in  input  DATA_WIDTH  word written when write accepted
data_out  output  DATA_WIDTH  registered read data
full  output  1  high when DEPTH entries stored
empty  output  1  high when 0 entries stored

Behaviour:
- Reset (rst=0, asynchronous): write pointer, read pointer, occupancy count -> 0; data_out -> 0; empty -> 1; full -> 0. Storage array not reset. Reset mid-operation discards all contents immediately.
- Pointers ADDR_WIDTH bits, wrap DEPTH-1 -> 0 naturally; occupancy count ADDR_WIDTH+1 bits (0..DEPTH).
- Write accepted when wr_en=1 and (full=0 or read accepted same cycle): mem[wr_ptr] <= data_in, wr_ptr increments.
- Read accepted when rd_en=1 and empty=0: data_out <= mem[rd_ptr] at that edge (one-cycle latency from rd_en sampled to data valid), rd_ptr increments.
- data_out holds its last value when no read is accepted.
- Write while full with no read: ignored; contents, pointers, flags unchanged.
- Read while empty: ignored; data_out holds; simultaneous write on empty is accepted (no read-through; word appears only via a later read).
- Simultaneous accepted read and write: count unchanged; read returns oldest entry, not data_in.
- Flags derived from next count and registered: empty = (count==0), full = (count==DEPTH); both update on same edge as the accepted operation.
- Order strictly preserved (first written, first read).

Optional Feature:
Macro FIFO_STATUS_EN. Defined: adds outputs count [ADDR_WIDTH:0] (current occupancy, reset 0), overflow (1-cycle pulse, registered, when wr_en=1 was rejected because full) and underflow (1-cycle pulse when rd_en=1 while empty); both reset 0. Undefined: these ports and their logic are absent; core behaviour identical.

Decomposition:
- Package fifo_pkg: default DATA_WIDTH/ADDR_WIDTH constants, DEPTH derivation helper, pointer/count typedefs.
- One sub-module natural: fifo_mem, simple dual-port array (one synchronous write port, one synchronous registered read port, no reset); fifo holds pointers, count, flags and optional status.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> data_out=00, empty=1, full=0; release, idle -> unchanged.
- Fill: write 01..10 (16 words) -> empty drops after first write, full=1 after 16th write, not before.
- Overflow: with full=1 write FF -> ignored, full stays 1; subsequent reads return 01..10 only (FF never appears); with FIFO_STATUS_EN overflow pulses one cycle, count=16.
- Drain: 16 reads -> data_out = 01,02,...,10 each one cycle after rd_en; full drops after first read, empty=1 after 16th; extra read -> data_out holds 10, empty=1 (underflow pulse if enabled).
- Wrap + simultaneous: write 8, read 4, then 12 cycles of wr_en=rd_en=1 with data 20.. -> count constant 4, outputs in exact write order across pointer wrap.
- Reset mid-operation: 5 words stored, assert rst between edges -> flags/data_out reset immediately without clock; next read after release ignored (empty=1).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
// Default word/address widths, depth helper and default-sized pointer/count types.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 4;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  typedef logic [ADDR_WIDTH_DEF-1:0] ptr_t;
  typedef logic [ADDR_WIDTH_DEF:0]   cnt_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port and one unregistered read port.
// The read register lives in the parent so that it can be cleared by reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: pointers, occupancy count, registered flags and read data.
// Define FIFO_STATUS_EN to add count/overflow/underflow status outputs.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
`ifdef FIFO_STATUS_EN
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  empty
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_CNT  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_full;
  logic                  r_empty;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign w_rd_acc = rd_en && !r_empty;
  assign w_wr_acc = wr_en && (!r_full || w_rd_acc);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + ONE_CNT;
      2'b01:   w_count_nxt = r_count - ONE_CNT;
      default: w_count_nxt = r_count;
    endcase
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ONE_PTR;
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + ONE_PTR;
        r_data_out <= w_rd_data;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign data_out = r_data_out;
  assign full     = r_full;
  assign empty    = r_empty;

`ifdef FIFO_STATUS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en && !w_wr_acc;
      r_underflow <= rd_en && r_empty;
    end
  end

  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo (16 x 8 default build).
// Status outputs are checked as well when FIFO_STATUS_EN is defined.
module tb_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef FIFO_STATUS_EN
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;

  fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
`ifdef FIFO_STATUS_EN
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_d;

    rst     = 1'b0;
    wr_en   = 1'($urandom);
    rd_en   = 1'($urandom);
    data_in = 8'($urandom);
    step();
    wr_en   = 1'($urandom);
    rd_en   = 1'($urandom);
    data_in = 8'($urandom);
    step();
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
`ifdef FIFO_STATUS_EN
    chk("rst_count", 32'(count), 32'd0);
`endif

    wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    rst = 1'b1;
    step();
    chk("idle_data", 32'(data_out), 32'h00);
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_full", 32'(full), 32'd0);

    // Fill with 01..10
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; data_in = 8'(i);
      step();
      chk("fill_empty", 32'(empty), 32'd0);
      chk("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
    end

    data_in = 8'hFF;
    step();
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_empty", 32'(empty), 32'd0);
`ifdef FIFO_STATUS_EN
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
`endif
    wr_en = 1'b0;
    step();
    chk("ovf_hold_full", 32'(full), 32'd1);
`ifdef FIFO_STATUS_EN
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
`endif

    // Drain: 01..10 in order, FF must never appear
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      step();
      chk("drain_data", 32'(data_out), 32'(i));
      chk("drain_full", 32'(full), 32'd0);
      chk("drain_empty", 32'(empty), (i == 16) ? 32'd1 : 32'd0);
    end
    step();
    chk("udf_data", 32'(data_out), 32'h10);
    chk("udf_empty", 32'(empty), 32'd1);
`ifdef FIFO_STATUS_EN
    chk("udf_pulse", 32'(underflow), 32'd1);
`endif
    rd_en = 1'b0;
    step();
`ifdef FIFO_STATUS_EN
    chk("udf_pulse_end", 32'(underflow), 32'd0);
`endif
    chk("udf_hold", 32'(data_out), 32'h10);

    // Write 11..18, read four back
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; data_in = 8'h11 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      step();
      chk("pre_rd", 32'(data_out), 32'h11 + 32'(i));
    end

    // 12 simultaneous read/write cycles; pointers wrap during this run
    for (int k = 0; k < 12; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h20 + 8'(k);
      step();
      exp_d = (k < 4) ? (8'h15 + 8'(k)) : (8'h20 + 8'(k - 4));
      chk("sim_data", 32'(data_out), 32'(exp_d));
      chk("sim_empty", 32'(empty), 32'd0);
      chk("sim_full", 32'(full), 32'd0);
`ifdef FIFO_STATUS_EN
      chk("sim_count", 32'(count), 32'd4);
`endif
    end
    rd_en = 1'b0; data_in = 8'h2C;
    step();
    wr_en = 1'b0;
    chk("pre_rst_empty", 32'(empty), 32'd0);

    // Asynchronous reset between edges, 5 words stored
    #2;
    rst = 1'b0;
    #1;
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_full", 32'(full), 32'd0);
    chk("async_data", 32'(data_out), 32'h00);
`ifdef FIFO_STATUS_EN
    chk("async_count", 32'(count), 32'd0);
`endif
    step();
    rst = 1'b1;
    rd_en = 1'b1;
    step();
    chk("post_rst_data", 32'(data_out), 32'h00);
    chk("post_rst_empty", 32'(empty), 32'd1);
    rd_en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
